guess_game_ctrl: RTL
====================

# guess_game_ctrl

Sequencing controller for the three-digit "xAyB" guessing game that drives the VGA text overlay. It latches the secret answer, accepts player guesses over a valid/ready handshake, and scores each guess serially, one digit per cycle, into exact-position (A) and wrong-position (B) counts. It also counts attempts and declares win or lose. Its registered outputs feed the overlay text generators for the hint line, the guess echo and the start/result banners.

## Interface
Parameters:
- MAX_TRIES, 8, number of scored guesses allowed before LOSE; legal range 1–15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- num_valid  in  1  digits num1..num3 are valid this cycle
- num_ready  out  1  controller can accept digits this cycle
- num1, num2, num3  in  4 each  BCD digits, most significant first
- new_game  in  1  level; leaves WIN/LOSE and returns to IDLE
- ans_loaded  out  1  answer is held; gates the "GAME START" banner
- guess1, guess2, guess3  out  4 each  last accepted valid guess
- a_cnt  out  2  exact-position matches of the last scored guess
- b_cnt  out  2  wrong-position matches of the last scored guess
- result_valid  out  1  one-cycle pulse when a_cnt/b_cnt update
- err  out  1  one-cycle pulse when a submission is rejected
- tries  out  4  number of scored guesses this game
- win, lose  out  1 each  level; high in WIN or LOSE state
- game_state  out  3  IDLE=0, WAIT=1, CHECK=2, REPORT=3, WIN=4, LOSE=5

## Operation
- States are IDLE, WAIT, CHECK, REPORT, WIN and LOSE.
- num_ready is decoded from the state. It is 1 only in IDLE and WAIT.
- A transfer happens when num_valid and num_ready are both high on a clock edge.
- A submission is invalid if any digit is greater than 9. When GG_DUP_CHECK_EN is defined, a submission is also invalid if any two digits are equal.
- IDLE:
  - A valid transfer latches the answer, sets ans_loaded, clears tries, a_cnt and b_cnt, and moves to WAIT.
  - An invalid transfer pulses err and stays in IDLE.
- WAIT:
  - A valid transfer latches guess1..3, clears the a/b accumulators, sets the digit index to 0 and moves to CHECK.
  - An invalid transfer pulses err, leaves the guess registers and tries unchanged, and stays in WAIT.
- CHECK (digit index k = 0, 1, 2, one per cycle):
  - Add 1 to A when guess digit k equals answer digit k.
  - Add the number of answer digits j ≠ k that equal guess digit k to B.
  - After k = 2, move to REPORT.
  - Accumulators are 3 bits wide. The outputs saturate at 3; saturation can only occur when GG_DUP_CHECK_EN is not defined.
- REPORT (one cycle):
  - result_valid = 1.
  - If a_cnt = 3, go to WIN.
  - Otherwise, if tries = MAX_TRIES, go to LOSE.
  - Otherwise, go to WAIT.
  - WIN takes precedence over LOSE on the final try.
- WIN and LOSE:
  - Hold every output.
  - num_valid is ignored.
  - new_game = 1 moves to IDLE and clears ans_loaded, tries, a_cnt, b_cnt and guess1..3.
- new_game is ignored in every other state.
- Reset values: state IDLE, ans_loaded 0, all digit registers 0, a_cnt 0, b_cnt 0, tries 0, result_valid 0, err 0, win 0, lose 0.
- Asserting reset mid-CHECK abandons the guess. tries is not incremented and result_valid is not pulsed.

## Timing
- Accept edge E0 (WAIT→CHECK). Digits are scored on edges E1, E2 and E3.
- E3 updates a_cnt, b_cnt and tries (tries+1) and enters REPORT. result_valid is high for the cycle after E3.
- E4 leaves REPORT. num_ready returns in the cycle after E4 if the next state is WAIT.
- Guess-to-guess throughput is therefore 5 cycles.
- err is registered. It is high for exactly the one cycle after the rejecting edge.
- win and lose rise in the cycle after E4.
- In the cycle after reset deasserts, state is IDLE and num_ready = 1.

## Configuration
- GG_DUP_CHECK_EN defined:
  - Submissions with repeated digits are rejected with err, both for the answer and for guesses.
  - a_cnt + b_cnt ≤ 3 is guaranteed.
- GG_DUP_CHECK_EN undefined:
  - Repeated digits are accepted.
  - B is the raw pairwise count, saturated to 3. No err is raised for duplicates.

## Test plan
- Answer 1,2,3 accepted in IDLE; guess 3,2,1 → result_valid 3 edges after acceptance, a_cnt=1, b_cnt=2, tries=1, state WAIT.
- Answer 4,5,6; guess 4,5,6 → a_cnt=3, b_cnt=0, win=1, num_ready=0; new_game → IDLE, ans_loaded=0, tries=0.
- MAX_TRIES=2, answer 1,2,3; guesses 7,8,9 then 7,8,9 → second REPORT leads to LOSE; a third num_valid is ignored.
- With GG_DUP_CHECK_EN: guess 5,5,1 → err pulse one cycle, tries unchanged, guess registers unchanged. Guess 1,10,2 → err pulse with or without the macro.
- Reset asserted during the second CHECK cycle → all outputs at reset values next cycle, no result_valid.
- num_valid held high continuously → exactly one acceptance per 5 cycles, with no transfer while num_ready=0.

Source files
------------

// File: rtl/guess_game_if.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_if
// Description : Bundle between the digit source / overlay and the xAyB game
//               controller.
//               Inputs to the controller: num_valid, num1..num3 (BCD, MS first)
//               and new_game.
//               Outputs from the controller: num_ready, ans_loaded,
//               guess1..guess3, a_cnt, b_cnt, result_valid, err, tries, win,
//               lose and game_state.
//               master = digit source / overlay side; slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface guess_game_if;
    logic       num_valid;
    logic       num_ready;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic       new_game;
    logic       ans_loaded;
    logic [3:0] guess1;
    logic [3:0] guess2;
    logic [3:0] guess3;
    logic [1:0] a_cnt;
    logic [1:0] b_cnt;
    logic       result_valid;
    logic       err;
    logic [3:0] tries;
    logic       win;
    logic       lose;
    logic [2:0] game_state;

    modport master (
        output num_valid, num1, num2, num3, new_game,
        input  num_ready, ans_loaded, guess1, guess2, guess3, a_cnt, b_cnt,
               result_valid, err, tries, win, lose, game_state
    );

    modport slave (
        input  num_valid, num1, num2, num3, new_game,
        output num_ready, ans_loaded, guess1, guess2, guess3, a_cnt, b_cnt,
               result_valid, err, tries, win, lose, game_state
    );
endinterface
`default_nettype wire

// File: rtl/guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_ctrl
// Description : Sequencing controller for the three-digit xAyB guessing game.
//               Latches the secret answer, accepts guesses over a valid/ready
//               handshake, scores one digit per cycle into exact-position (A)
//               and wrong-position (B) counts, counts attempts and declares
//               win or lose. All outputs are registered or decoded from the
//               state register.
// Ports       : clk   - system clock
//               reset - synchronous, active-high
//               bus   - guess_game_if.slave (handshake, digits, results)
// Parameters  : MAX_TRIES - scored guesses allowed before LOSE (1..15)
// Build macro : GG_DUP_CHECK_EN - when defined, submissions with repeated
//               digits are rejected with err (answer and guesses).
// Revision    : 1.0 - initial release
// ============================================================================
module guess_game_ctrl #(
    parameter int MAX_TRIES = 8
) (
    input  logic         clk,
    input  logic         reset,
    guess_game_if.slave  bus
);

    localparam logic [3:0] c_MAX_TRIES = 4'(MAX_TRIES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_REPORT = 3'd3,
        ST_WIN    = 3'd4,
        ST_LOSE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [0:2][3:0]   ans_q, ans_d;      // [0] is the most significant digit
    logic [0:2][3:0]   guess_q, guess_d;
    logic [2:0]        acc_a_q, acc_a_d;
    logic [2:0]        acc_b_q, acc_b_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        a_cnt_q, a_cnt_d;
    logic [1:0]        b_cnt_q, b_cnt_d;
    logic [3:0]        tries_q, tries_d;
    logic              result_valid_q, result_valid_d;
    logic              err_q, err_d;
    logic              loaded_q, loaded_d;

    logic              w_ready;
    logic              w_xfer;
    logic              w_range_ok;
    logic              w_dup;
    logic              w_in_ok;
    logic [0:2][3:0]   w_in_digits;
    logic [3:0]        w_gk;
    logic              w_a_inc;
    logic [1:0]        w_b_inc;
    logic [2:0]        w_acc_a_nxt;
    logic [2:0]        w_acc_b_nxt;

    function automatic logic [1:0] sat3(input logic [2:0] v);
        return (v > 3'd3) ? 2'd3 : v[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Submission qualification
    // ------------------------------------------------------------------
    assign w_in_digits = {bus.num1, bus.num2, bus.num3};
    assign w_ready     = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    assign w_xfer      = bus.num_valid && w_ready;

    always_comb begin
        w_range_ok = (bus.num1 <= 4'd9) && (bus.num2 <= 4'd9) && (bus.num3 <= 4'd9);
`ifdef GG_DUP_CHECK_EN
        w_dup = (bus.num1 == bus.num2) || (bus.num1 == bus.num3) ||
                (bus.num2 == bus.num3);
`else
        w_dup = 1'b0;
`endif
    end

    assign w_in_ok = w_range_ok && !w_dup;

    // ------------------------------------------------------------------
    // Serial scoring of guess digit idx_q against the whole answer
    // ------------------------------------------------------------------
    always_comb begin
        case (idx_q)
            2'd0:    w_gk = guess_q[0];
            2'd1:    w_gk = guess_q[1];
            default: w_gk = guess_q[2];
        endcase
        w_a_inc = 1'b0;
        w_b_inc = 2'd0;
        for (int j = 0; j < 3; j++) begin
            if (ans_q[j] == w_gk) begin
                if (j[1:0] == idx_q) begin
                    w_a_inc = 1'b1;
                end else begin
                    w_b_inc = w_b_inc + 2'd1;
                end
            end
        end
    end

    // Raw B can reach 6 with repeated digits, hence the 3-bit accumulators.
    assign w_acc_a_nxt = acc_a_q + {2'b00, w_a_inc};
    assign w_acc_b_nxt = acc_b_q + {1'b0, w_b_inc};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ans_q          <= '0;
            guess_q        <= '0;
            acc_a_q        <= 3'd0;
            acc_b_q        <= 3'd0;
            idx_q          <= 2'd0;
            a_cnt_q        <= 2'd0;
            b_cnt_q        <= 2'd0;
            tries_q        <= 4'd0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            loaded_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ans_q          <= ans_d;
            guess_q        <= guess_d;
            acc_a_q        <= acc_a_d;
            acc_b_q        <= acc_b_d;
            idx_q          <= idx_d;
            a_cnt_q        <= a_cnt_d;
            b_cnt_q        <= b_cnt_d;
            tries_q        <= tries_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            loaded_q       <= loaded_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        ans_d          = ans_q;
        guess_d        = guess_q;
        acc_a_d        = acc_a_q;
        acc_b_d        = acc_b_q;
        idx_d          = idx_q;
        a_cnt_d        = a_cnt_q;
        b_cnt_d        = b_cnt_q;
        tries_d        = tries_q;
        loaded_d       = loaded_q;
        result_valid_d = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_in_ok) begin
                        ans_d    = w_in_digits;
                        loaded_d = 1'b1;
                        tries_d  = 4'd0;
                        a_cnt_d  = 2'd0;
                        b_cnt_d  = 2'd0;
                        state_d  = ST_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (w_xfer) begin
                    if (w_in_ok) begin
                        guess_d = w_in_digits;
                        acc_a_d = 3'd0;
                        acc_b_d = 3'd0;
                        idx_d   = 2'd0;
                        state_d = ST_CHECK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_CHECK: begin
                acc_a_d = w_acc_a_nxt;
                acc_b_d = w_acc_b_nxt;
                idx_d   = idx_q + 2'd1;
                // Last digit: publish the totals straight from the adders so
                // the visible counts move together with tries.
                if (idx_q == 2'd2) begin
                    a_cnt_d        = sat3(w_acc_a_nxt);
                    b_cnt_d        = sat3(w_acc_b_nxt);
                    tries_d        = tries_q + 4'd1;
                    result_valid_d = 1'b1;
                    state_d        = ST_REPORT;
                end
            end

            ST_REPORT: begin
                // A win on the final try beats the loss.
                if (a_cnt_q == 2'd3) begin
                    state_d = ST_WIN;
                end else if (tries_q == c_MAX_TRIES) begin
                    state_d = ST_LOSE;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WIN, ST_LOSE: begin
                if (bus.new_game) begin
                    state_d  = ST_IDLE;
                    loaded_d = 1'b0;
                    tries_d  = 4'd0;
                    a_cnt_d  = 2'd0;
                    b_cnt_d  = 2'd0;
                    guess_d  = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.num_ready    = w_ready;
    assign bus.ans_loaded   = loaded_q;
    assign bus.guess1       = guess_q[0];
    assign bus.guess2       = guess_q[1];
    assign bus.guess3       = guess_q[2];
    assign bus.a_cnt        = a_cnt_q;
    assign bus.b_cnt        = b_cnt_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;
    assign bus.tries        = tries_q;
    assign bus.win          = (state_q == ST_WIN);
    assign bus.lose         = (state_q == ST_LOSE);
    assign bus.game_state   = state_q;

endmodule
`default_nettype wire
